// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, sequencer state encoding and helpers for muldiv_seq.
// Contents: OP_* instruction codes, state_t (IDLE/MUL/DIV/FIX), DIV_CYCLES, CNT_W, mag32().
// No logic of its own; imported by muldiv_seq and div_step.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // One restoring step per quotient bit.
  localparam int DIV_CYCLES = 32;

  // Counter width: holds DIV_CYCLES (32) and MUL_LAT (1..8).
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Two's-complement magnitude. 32'h8000_0000 maps to itself, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration on unsigned magnitudes.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller registers the outputs once per cycle.
// Ports: rem_in/quo_in/dvs in (partial remainder, quotient/dividend shift
//        register, divisor); rem_out/quo_out are the next iteration state.
module div_step
  import muldiv_pkg::*;
(
  input  logic [32:0] rem_in,
  input  logic [31:0] quo_in,
  input  logic [31:0] dvs,
  output logic [32:0] rem_out,
  output logic [31:0] quo_out
);

  logic [33:0] shifted;
  logic [33:0] trial;

  // Shift the next dividend bit into the remainder and try to subtract the
  // divisor. A set MSB means the subtraction went negative: restore.
  assign shifted = {rem_in, quo_in[31]};
  assign trial   = shifted - {2'b00, dvs};

  always_comb begin
    rem_out = shifted[32:0];
    quo_out = {quo_in[30:0], 1'b0};
    if (!trial[33]) begin
      rem_out = trial[32:0];
      quo_out = {quo_in[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning HI/LO.
// Latency: MTHI/MTLO 1 cycle; MUL MUL_LAT cycles; DIV 33 cycles (32 steps + sign fix).
// Backpressure: start is ignored while busy; stall = busy & (start | rd_hilo) holds the pipe.
// Ports: clk, rst (sync, active-high); start/op/a/b issue an instruction;
//        rd_hilo flags MFHI/MFLO in execute; cancel aborts the in-flight op;
//        hi/lo are the architectural registers; busy/stall/done report progress.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hilo,
  input  logic        cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Multiply operands; op_a also keeps the raw dividend for divide-by-zero.
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mul_sgn;

  // Divide datapath, all on magnitudes.
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;

  logic [32:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        div_sgn;

  div_step u_div_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .dvs     (dvs),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // Extend to 64 bits first; the low 64 bits of the product are then correct
  // for both signed and unsigned operands.
  assign ext_a   = mul_sgn ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
  assign ext_b   = mul_sgn ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
  assign product = ext_a * ext_b;

  // Truncating division: quotient negative when signs differ, remainder
  // follows the dividend.
  assign q_fix = neg_q ? (~quo + 32'd1) : quo;
  assign r_fix = neg_r ? (~rem[31:0] + 32'd1) : rem[31:0];

  assign div_sgn = (op == OP_DIV);

  assign busy  = (state != IDLE);
  assign stall = busy & (start | rd_hilo);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      mul_sgn  <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              OP_MULT, OP_MULTU: begin
                op_a    <= a;
                op_b    <= b;
                mul_sgn <= (op == OP_MULT);
                cnt     <= CNT_W'(MUL_LAT);
                state   <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                op_a     <= a;
                rem      <= '0;
                quo      <= div_sgn ? mag32(a) : a;
                dvs      <= div_sgn ? mag32(b) : b;
                neg_q    <= div_sgn & (a[31] ^ b[31]);
                neg_r    <= div_sgn & a[31];
                div_zero <= (b == 32'd0);
                cnt      <= CNT_W'(DIV_CYCLES);
                state    <= DIV;
              end
              default: ;
            endcase
          end
        end

        MUL: begin
          if (cancel) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(1)) begin
            {hi, lo} <= product;
            done     <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DIV: begin
          if (cancel) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
          end
        end

        FIX: begin
          if (!cancel) begin
            if (div_zero) begin
              lo <= 32'hFFFF_FFFF;
              hi <= op_a;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
            done <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq (MUL_LAT = 4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Every wait on busy is bounded; an expired bound shows up as a wrong cycle count.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hilo;
  logic        cancel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.MUL_LAT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .rd_hilo (rd_hilo),
    .cancel  (cancel),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall   (stall),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Counts cycles with busy high, starting from the sample right after acceptance.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  // Present one instruction for one edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int stall_bad;

    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; rd_hilo = 1'b0; cancel = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rd_hilo = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    rd_hilo = 1'b0;

    // MTHI: visible next cycle, never busy.
    issue(3'b100, 32'h1234_5678, 32'h0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);

    // MULT -3 * 7 = -21.
    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    wait_idle(n);
    check("mult_cycles", n, 32'd4);
    check("mult_done", {31'd0, done}, 32'd1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    // MULTU issued back-to-back in the done cycle.
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("mult_done_pulse", {31'd0, done}, 32'd0);
    wait_idle(n);
    check("multu_cycles", n, 32'd4);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    step();
    check("multu_done_clr", {31'd0, done}, 32'd0);

    // DIV -7 / 2 = -3 rem -1.
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, 32'd33);
    check("div_done", {31'd0, done}, 32'd1);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 100 / 7 = 14 rem 2.
    issue(3'b011, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_cycles", n, 32'd33);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // Hazards: rd_hilo held through a DIV (50/5), MULT 3*4 presented at cycle 5.
    issue(3'b010, 32'd50, 32'd5);
    rd_hilo   = 1'b1;
    n         = 0;
    stall_bad = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (stall !== 1'b1) stall_bad++;
      if (n == 5) begin
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
        #1;
        if (stall !== 1'b1) stall_bad++;
      end
      step();
      start = 1'b0;
    end
    check("haz_cycles", n, 32'd33);
    check("haz_stall_bad", stall_bad, 32'd0);
    check("haz_stall_idle", {31'd0, stall}, 32'd0);
    check("haz_lo", lo, 32'd10);
    check("haz_hi", hi, 32'd0);
    rd_hilo = 1'b0;
    issue(3'b000, 32'd3, 32'd4);
    wait_idle(n);
    check("reissue_cycles", n, 32'd4);
    check("reissue_lo", lo, 32'd12);
    check("reissue_hi", hi, 32'd0);

    // Divide by zero, unsigned and signed.
    issue(3'b011, 32'd9, 32'd0);
    wait_idle(n);
    check("divu0_cycles", n, 32'd33);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd9);
    issue(3'b010, 32'hFFFF_FFFB, 32'd0);
    wait_idle(n);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'hFFFF_FFFB);

    // Cancel at cycle 10 of a DIVU.
    issue(3'b011, 32'd100, 32'd7);
    for (int i = 1; i < 10; i++) step();
    check("cxl_busy_before", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cxl_busy", {31'd0, busy}, 32'd0);
    check("cxl_done", {31'd0, done}, 32'd0);
    check("cxl_lo", lo, 32'hFFFF_FFFF);
    check("cxl_hi", hi, 32'hFFFF_FFFB);
    step();
    check("cxl_done_after", {31'd0, done}, 32'd0);

    // cancel blocks MTHI in IDLE; reserved op is ignored.
    cancel = 1'b1;
    issue(3'b100, 32'hAAAA_5555, 32'h0);
    cancel = 1'b0;
    check("cxl_mthi_hi", hi, 32'hFFFF_FFFB);
    issue(3'b110, 32'd1, 32'd1);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_lo", lo, 32'hFFFF_FFFF);

    // Reset mid-MUL.
    issue(3'b000, 32'd3, 32'd4);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmul_hi", hi, 32'h0);
    check("rstmul_lo", lo, 32'h0);
    check("rstmul_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    check("rstmul_done", {31'd0, done}, 32'd0);
    check("rstmul_lo_late", lo, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
